// File: rtl/ascii_ps2_sender.sv
// PS/2 set-2 keyboard emulator: each accepted ASCII character becomes make, F0, make (ASCII_PS2_SENDER_SHIFT_EN adds 12-wrapped shifted keys).
// Start bit appears the cycle after acceptance; ready stays low until the last gap cycle of the final byte has elapsed.
module ascii_ps2_sender #(
  parameter int HALF_CYC = 8,
  parameter int GAP_CYC  = 32
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] ascii_in,
  input  logic       valid,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       err
);

`ifdef ASCII_PS2_SENDER_SHIFT_EN
  localparam int NBUF = 6;
`else
  localparam int NBUF = 3;
`endif

  localparam logic [10:0] LP_HALF_LAST = 11'(HALF_CYC - 1);
  localparam logic [10:0] LP_BIT_LAST  = 11'(2 * HALF_CYC - 1);
  localparam logic [9:0]  LP_GAP_LAST  = 10'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  function automatic logic [8:0] base_code(input logic [7:0] c);
    logic [8:0] r;
    r = 9'h000;
    case (c)
      8'h61: r = 9'h11C;
      8'h62: r = 9'h132;
      8'h63: r = 9'h121;
      8'h64: r = 9'h123;
      8'h65: r = 9'h124;
      8'h66: r = 9'h12B;
      8'h67: r = 9'h134;
      8'h68: r = 9'h133;
      8'h69: r = 9'h143;
      8'h6A: r = 9'h13B;
      8'h6B: r = 9'h142;
      8'h6C: r = 9'h14B;
      8'h6D: r = 9'h13A;
      8'h6E: r = 9'h131;
      8'h6F: r = 9'h144;
      8'h70: r = 9'h14D;
      8'h71: r = 9'h115;
      8'h72: r = 9'h12D;
      8'h73: r = 9'h11B;
      8'h74: r = 9'h12C;
      8'h75: r = 9'h13C;
      8'h76: r = 9'h12A;
      8'h77: r = 9'h11D;
      8'h78: r = 9'h122;
      8'h79: r = 9'h135;
      8'h7A: r = 9'h11A;
      8'h30: r = 9'h145;
      8'h31: r = 9'h116;
      8'h32: r = 9'h11E;
      8'h33: r = 9'h126;
      8'h34: r = 9'h125;
      8'h35: r = 9'h12E;
      8'h36: r = 9'h136;
      8'h37: r = 9'h13D;
      8'h38: r = 9'h13E;
      8'h39: r = 9'h146;
      // punctuation on the unshifted key positions
      8'h60: r = 9'h10E;
      8'h2D: r = 9'h14E;
      8'h3D: r = 9'h155;
      8'h5C: r = 9'h15D;
      8'h5B: r = 9'h154;
      8'h5D: r = 9'h15B;
      8'h3B: r = 9'h14C;
      8'h27: r = 9'h152;
      8'h2C: r = 9'h141;
      8'h2E: r = 9'h149;
      8'h2F: r = 9'h14A;
      8'h20: r = 9'h129;
      8'h0D: r = 9'h15A;
      8'h09: r = 9'h10D;
      8'h08: r = 9'h166;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

`ifdef ASCII_PS2_SENDER_SHIFT_EN
  function automatic logic [8:0] shift_code(input logic [7:0] c);
    logic [8:0] r;
    r = 9'h000;
    if (c >= 8'h41 && c <= 8'h5A) begin
      r = base_code(c | 8'h20);
    end else begin
      case (c)
        8'h21: r = 9'h116;
        8'h40: r = 9'h11E;
        8'h23: r = 9'h126;
        8'h24: r = 9'h125;
        8'h25: r = 9'h12E;
        8'h5E: r = 9'h136;
        8'h26: r = 9'h13D;
        8'h2A: r = 9'h13E;
        8'h28: r = 9'h146;
        8'h29: r = 9'h145;
        8'h5F: r = 9'h14E;
        8'h2B: r = 9'h155;
        8'h7B: r = 9'h154;
        8'h7D: r = 9'h15B;
        8'h3A: r = 9'h14C;
        8'h22: r = 9'h152;
        8'h3C: r = 9'h141;
        8'h3E: r = 9'h149;
        8'h3F: r = 9'h14A;
        8'h7E: r = 9'h10E;
        8'h7C: r = 9'h15D;
        default: r = 9'h000;
      endcase
    end
    return r;
  endfunction
`endif

  state_t            r_state;
  logic [NBUF*8-1:0] r_buf;
  logic [2:0]        r_left;
  logic [10:0]       r_cnt;
  logic [3:0]        r_bit;
  logic [9:0]        r_gap;
  logic              r_ready;
  logic              r_clk;
  logic              r_data;
  logic              r_err;

  logic [8:0]        w_base;
`ifdef ASCII_PS2_SENDER_SHIFT_EN
  logic [8:0]        w_shift;
`endif
  logic [NBUF*8-1:0] w_seq;
  logic [2:0]        w_nbytes;
  logic              w_mapped;
  logic              w_accept;
  logic [10:0]       w_frame;
  logic              w_next_bit;

  // Sequence is packed first-byte-in-LSB so the buffer simply shifts right per byte.
  always_comb begin
    w_base   = base_code(ascii_in);
    w_seq    = '0;
    w_nbytes = 3'd0;
`ifdef ASCII_PS2_SENDER_SHIFT_EN
    w_shift  = shift_code(ascii_in);
`endif
    if (w_base[8]) begin
      w_seq[23:0] = {w_base[7:0], 8'hF0, w_base[7:0]};
      w_nbytes    = 3'd3;
    end
`ifdef ASCII_PS2_SENDER_SHIFT_EN
    else if (w_shift[8]) begin
      w_seq    = {8'h12, 8'hF0, w_shift[7:0], 8'hF0, w_shift[7:0], 8'h12};
      w_nbytes = 3'd6;
    end
`endif
  end

  assign w_mapped   = (w_nbytes != 3'd0);
  assign w_accept   = valid & r_ready;
  assign w_frame    = {1'b1, ~^r_buf[7:0], r_buf[7:0], 1'b0};
  assign w_next_bit = w_frame[r_bit + 4'd1];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_left  <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_ready <= 1'b1;
      r_clk   <= 1'b1;
      r_data  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_mapped) begin
              r_buf   <= w_seq;
              r_left  <= w_nbytes - 3'd1;
              r_cnt   <= '0;
              r_bit   <= '0;
              r_clk   <= 1'b1;
              r_data  <= 1'b0;
              r_ready <= 1'b0;
              r_state <= FRAME;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        FRAME: begin
          // Data moves only at the start of a high phase, so it is stable at every falling edge.
          if (r_cnt == LP_BIT_LAST) begin
            r_cnt <= '0;
            r_clk <= 1'b1;
            if (r_bit == 4'd10) begin
              r_data  <= 1'b1;
              r_gap   <= '0;
              r_state <= GAP;
            end else begin
              r_bit  <= r_bit + 4'd1;
              r_data <= w_next_bit;
            end
          end else begin
            r_cnt <= r_cnt + 11'd1;
            if (r_cnt == LP_HALF_LAST) begin
              r_clk <= 1'b0;
            end
          end
        end
        GAP: begin
          if (r_gap == LP_GAP_LAST) begin
            r_gap <= '0;
            if (r_left != 3'd0) begin
              r_left  <= r_left - 3'd1;
              r_buf   <= r_buf >> 8;
              r_bit   <= '0;
              r_cnt   <= '0;
              r_data  <= 1'b0;
              r_state <= FRAME;
            end else begin
              r_ready <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_gap <= r_gap + 10'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready    = r_ready;
  assign ps2_clk  = r_clk;
  assign ps2_data = r_data;
  assign err      = r_err;

endmodule

// File: tb/tb_ascii_ps2_sender.sv
// Bench for ascii_ps2_sender: cycle-level waveform model built from the framing rules, plus a falling-edge decoder.
`timescale 1ns/1ps
module tb_ascii_ps2_sender;
  localparam int HALF = 8;
  localparam int GAP  = 32;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic       valid = 1'b0;
  logic       ready, ps2_clk, ps2_data, err;

  ascii_ps2_sender #(.HALF_CYC(HALF), .GAP_CYC(GAP)) dut (
    .clk(clk), .clrn(clrn), .ascii_in(ascii_in), .valid(valid),
    .ready(ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] unsh_tab [51] = '{
    16'h611C, 16'h6232, 16'h6321, 16'h6423, 16'h6524, 16'h662B, 16'h6734, 16'h6833, 16'h6943,
    16'h6A3B, 16'h6B42, 16'h6C4B, 16'h6D3A, 16'h6E31, 16'h6F44, 16'h704D, 16'h7115, 16'h722D,
    16'h731B, 16'h742C, 16'h753C, 16'h762A, 16'h771D, 16'h7822, 16'h7935, 16'h7A1A,
    16'h3045, 16'h3116, 16'h321E, 16'h3326, 16'h3425, 16'h352E, 16'h3636, 16'h373D, 16'h383E, 16'h3946,
    16'h600E, 16'h2D4E, 16'h3D55, 16'h5C5D, 16'h5B54, 16'h5D5B, 16'h3B4C, 16'h2752, 16'h2C41, 16'h2E49, 16'h2F4A,
    16'h2029, 16'h0D5A, 16'h090D, 16'h0866
  };
`ifdef ASCII_PS2_SENDER_SHIFT_EN
  logic [15:0] shft_tab [21] = '{
    16'h2116, 16'h401E, 16'h2326, 16'h2425, 16'h252E, 16'h5E36, 16'h263D, 16'h2A3E, 16'h2846, 16'h2945,
    16'h5F4E, 16'h2B55, 16'h7B54, 16'h7D5B, 16'h3A4C, 16'h2252, 16'h3C41, 16'h3E49, 16'h3F4A, 16'h7E0E, 16'h7C5D
  };
`endif

  // ---------------- model ----------------
  logic [7:0] seq_q [$];
  logic [2:0] exp_q [$];
  logic exp_clk = 1'b1, exp_data = 1'b1, exp_ready = 1'b1, exp_err = 1'b0;
  int   acc_cnt = 0;
  logic chk_en = 1'b0;

  task automatic build_seq(input logic [7:0] c);
    logic       hit;
    logic [7:0] k;
    seq_q.delete();
    hit = 1'b0;
    k   = 8'h00;
    for (int i = 0; i < 51; i++)
      if (unsh_tab[i][15:8] == c) begin hit = 1'b1; k = unsh_tab[i][7:0]; end
    if (hit) begin
      seq_q.push_back(k); seq_q.push_back(8'hF0); seq_q.push_back(k);
    end
`ifdef ASCII_PS2_SENDER_SHIFT_EN
    else begin
      if (c >= 8'h41 && c <= 8'h5A)
        for (int i = 0; i < 51; i++)
          if (unsh_tab[i][15:8] == (c + 8'h20)) begin hit = 1'b1; k = unsh_tab[i][7:0]; end
      for (int i = 0; i < 21; i++)
        if (shft_tab[i][15:8] == c) begin hit = 1'b1; k = shft_tab[i][7:0]; end
      if (hit) begin
        seq_q.push_back(8'h12); seq_q.push_back(k); seq_q.push_back(8'hF0);
        seq_q.push_back(k); seq_q.push_back(8'hF0); seq_q.push_back(8'h12);
      end
    end
`endif
  endtask

  // Expand bytes into per-cycle {ps2_clk, ps2_data, ready} expectations.
  task automatic push_frames();
    logic [10:0] f;
    foreach (seq_q[j]) begin
      f = {1'b1, ~^seq_q[j], seq_q[j], 1'b0};
      for (int b = 0; b < 11; b++) begin
        repeat (HALF) exp_q.push_back({1'b1, f[b], 1'b0});
        repeat (HALF) exp_q.push_back({1'b0, f[b], 1'b0});
      end
      repeat (GAP) exp_q.push_back(3'b110);
    end
  endtask

  always @(posedge clk) begin
    if (!clrn) begin
      exp_q.delete();
      {exp_clk, exp_data, exp_ready, exp_err} = 4'b1110;
    end else begin
      exp_err = 1'b0;
      if (valid && exp_ready) begin
        acc_cnt++;
        build_seq(ascii_in);
        if (seq_q.size() == 0) exp_err = 1'b1;
        else push_frames();
      end
      if (exp_q.size() > 0) {exp_clk, exp_data, exp_ready} = exp_q.pop_front();
      else {exp_clk, exp_data, exp_ready} = 3'b111;
    end
  end

  // ---------------- checking ----------------
  task automatic check_bit(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  int rlow = 0, nerr = 0, nfall = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("cyc_ps2_clk", ps2_clk, exp_clk);
      check_bit("cyc_ps2_data", ps2_data, exp_data);
      check_bit("cyc_ready", ready, exp_ready);
      check_bit("cyc_err", err, exp_err);
      if (ready === 1'b0) rlow++;
      if (err === 1'b1) nerr++;
    end
  end

  logic [7:0]  dec_q [$];
  logic [10:0] raw_q [$];
  logic [10:0] dec_raw = '0;
  int          dec_n = 0;

  always @(negedge ps2_clk or negedge clrn) begin
    if (!clrn) begin
      dec_n = 0;
    end else if (chk_en) begin
      nfall++;
      dec_raw[dec_n] = ps2_data;
      dec_n++;
      if (dec_n == 11) begin
        dec_n = 0;
        dec_q.push_back(dec_raw[8:1]);
        raw_q.push_back(dec_raw);
        check_int("frame_start", int'(dec_raw[0]), 0);
        check_int("frame_odd_parity", int'(^dec_raw[9:1]), 1);
        check_int("frame_stop", int'(dec_raw[10]), 1);
      end
    end
  end

  // Expected bytes packed with the first byte in the most significant position of n bytes.
  task automatic check_dec(input string nm, input int n, input logic [47:0] v);
    check_int($sformatf("%s_nbytes", nm), dec_q.size(), n);
    for (int i = 0; i < n && i < dec_q.size(); i++)
      check_int($sformatf("%s_byte%0d", nm, i), int'(dec_q[i]), int'(v[8*(n-1-i) +: 8]));
    dec_q.delete();
    raw_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    ascii_in = c;
    valid    = 1'b1;
    step();
    valid    = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ready !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d cycles required=<%0d", nm, n, budget);
    end
    repeat (2) step();
  endtask

  task automatic clear_counts();
    rlow = 0; nerr = 0; nfall = 0;
  endtask

  logic [15:0] simple_tab [5] = '{16'h0D5A, 16'h090D, 16'h0866, 16'h2F4A, 16'h3045};

  initial begin
    int n;
    int acc0;
    repeat (3) @(posedge clk);
    #1;
    clrn   = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check_int("rst_ps2_clk", int'(ps2_clk), 1);
    check_int("rst_ps2_data", int'(ps2_data), 1);
    check_int("rst_ready", int'(ready), 1);
    check_int("rst_err", int'(err), 0);
    step();

    // 'a'
    clear_counts();
    send_char(8'h61);
    wait_idle("a", 2000);
    check_int("a_frame0_bits", int'(raw_q.size() > 0 ? raw_q[0] : 11'h0), 11'h438);
    check_int("a_f0_parity", int'(raw_q.size() > 1 ? raw_q[1][9] : 1'b0), 1);
    check_int("a_ready_low", rlow, 3 * (22 * HALF + GAP));
    check_dec("a", 3, {8'h1C, 8'hF0, 8'h1C});

    // unmapped 0x80
    clear_counts();
    send_char(8'h80);
    repeat (40) step();
    check_int("unmapped_err_cycles", nerr, 1);
    check_int("unmapped_falls", nfall, 0);
    check_int("unmapped_ready_low", rlow, 0);
    check_dec("unmapped", 0, 48'h0);

    // held valid, data changes mid-transmission, back-to-back second character
    clear_counts();
    acc0     = acc_cnt;
    ascii_in = 8'h31;
    valid    = 1'b1;
    n = 0;
    while (acc_cnt < acc0 + 2 && n < 3000) begin
      step();
      n++;
      if (n == 100) ascii_in = 8'h32;
    end
    valid = 1'b0;
    check_int("hold_accepts", acc_cnt - acc0, 2);
    wait_idle("hold", 2000);
    check_int("hold_falls", nfall, 66);
    check_dec("hold", 6, {8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E});

    // reset during bit 4 of 'z'
    clear_counts();
    send_char(8'h7A);
    repeat (69) step();
    check_int("abort_falls_before", nfall, 4);
    clrn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_int("abort_ps2_clk", int'(ps2_clk), 1);
    check_int("abort_ps2_data", int'(ps2_data), 1);
    check_int("abort_ready", int'(ready), 1);
    clrn  = 1'b1;
    nfall = 0;
    repeat (700) step();
    check_int("abort_falls_after", nfall, 0);
    check_dec("abort", 0, 48'h0);

    // space
    clear_counts();
    send_char(8'h20);
    wait_idle("space", 2000);
    check_dec("space", 3, {8'h29, 8'hF0, 8'h29});

    foreach (simple_tab[i]) begin
      send_char(simple_tab[i][15:8]);
      wait_idle("tab", 2000);
      check_dec($sformatf("char%02h", simple_tab[i][15:8]), 3,
                {8'h00, simple_tab[i][7:0], 8'hF0, simple_tab[i][7:0]});
    end

    // 'A'
    clear_counts();
    send_char(8'h41);
`ifdef ASCII_PS2_SENDER_SHIFT_EN
    wait_idle("upper", 3000);
    check_int("upper_err_cycles", nerr, 0);
    check_dec("upper", 6, {8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
`else
    repeat (40) step();
    check_int("upper_err_cycles", nerr, 1);
    check_int("upper_falls", nfall, 0);
    check_dec("upper", 0, 48'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascii_ps2_sender.md
ASCII_PS2_SENDER -- requirements
Module: ascii_ps2_sender

Interface
REQ-001 SHALL have parameter HALF_CYC, default 8: system-clock cycles per half PS/2 clock period (legal values 2..1023).
REQ-002 SHALL have parameter GAP_CYC, default 32: idle cycles after every frame, with ps2_clk=1 and ps2_data=1 (legal values 1..1023).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port clrn, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port ascii_in, input, 8 bits: character to send.
REQ-006 SHALL have port valid, input, 1 bit: ascii_in is valid.
REQ-007 SHALL have port ready, output, 1 bit: the block can accept a character.
REQ-008 SHALL have port ps2_clk, output, 1 bit: emulated keyboard clock, idle high.
REQ-009 SHALL have port ps2_data, output, 1 bit: emulated keyboard data, idle high.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse when a character has no mapping.

Function
REQ-011 SHALL accept a character on a rising clk edge where valid=1 and ready=1; valid while ready=0 is ignored.
REQ-012 SHALL map ASCII to set-2 make codes: a-z, 0-9, ` - = \ [ ] ; ' , . /, space 0x20->29, enter 0x0D->5A, tab 0x09->0D, backspace 0x08->66.
REQ-013 SHALL send 3 bytes for a mapped character: the make code, then F0, then the make code.
REQ-014 SHALL, for an unmapped character, pulse err=1 for the cycle after acceptance, produce no ps2_clk edges, and keep ready=1.
REQ-015 SHALL send each byte as an 11-bit frame: start 0, data bits LSB first, odd parity, stop 1.
REQ-016 SHALL drive each bit in two phases: ps2_clk=1 for HALF_CYC cycles, then ps2_clk=0 for HALF_CYC cycles.
REQ-017 SHALL change ps2_data only on the first cycle of a bit's high phase; ps2_data stays stable across that bit's falling ps2_clk edge.
REQ-018 SHALL take exactly 22*HALF_CYC cycles per frame, followed by GAP_CYC gap cycles.
REQ-019 SHALL drive the start bit (ps2_data=0) on the cycle after acceptance.
REQ-020 SHALL hold ready=0 from the cycle after acceptance until the last gap cycle of the final byte; ready=1 on the following cycle.
REQ-021 SHALL implement the states IDLE, FRAME and GAP:
- IDLE->FRAME on a mapped acceptance.
- FRAME->GAP after bit 10.
- GAP->FRAME if bytes remain; GAP->IDLE otherwise.
REQ-022 SHALL latch the byte sequence at acceptance; ascii_in changes during transmission have no effect.
REQ-023 SHALL give a back-to-back valid on the cycle ready returns to 1 the same start-bit latency, with no extra gap.

Reset
REQ-024 SHALL, while clrn=0 at a clk edge, force:
- state=IDLE
- ps2_clk=1, ps2_data=1, ready=1, err=0
- all counters and the byte buffer to 0
REQ-025 SHALL abort a transmission in progress when reset is applied mid-frame; no partial bits resume after reset.

Configuration
REQ-026 SHALL, when macro ASCII_PS2_SENDER_SHIFT_EN is defined, map A-Z and the shifted symbols (! @ # $ % ^ & * ( ) _ + { } : " < > ? ~ |) to the sequence 12, make, F0, make, F0, 12 (6 frames).
REQ-027 SHALL, when ASCII_PS2_SENDER_SHIFT_EN is undefined, treat A-Z and the shifted symbols as unmapped (err pulse, per REQ-014), and size the byte buffer at 3 entries.

Verification (HALF_CYC=8, GAP_CYC=32)
REQ-028 'a' (0x61) -> frames 1C,F0,1C:
- 1C bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0); F0 parity bit 1.
- ready=0 for exactly 3*(176+32) cycles.
REQ-029 0x80 -> err high for 1 cycle, ps2_clk constantly 1, ready=1 throughout.
REQ-030 Hold valid=1 with '1' (0x31) then change ascii_in to '2' mid-transmission -> only 16,F0,16 are sent; '2' is sent next only if still valid when ready rises.
REQ-031 Assert clrn=0 for 1 cycle during bit 4 of the first frame of 'z' -> next cycle ps2_clk=1, ps2_data=1, ready=1, and no further edges occur.
REQ-032 Sample ps2_data on every falling ps2_clk edge for ' ' (0x20) -> decoded bytes 29,F0,29, all with correct odd parity and stop=1.
REQ-033 With ASCII_PS2_SENDER_SHIFT_EN defined, 'A' (0x41) -> 12,1C,F0,1C,F0,12; without it -> err pulse and no frames.
